multicycle_controller: RTL and testbench

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

---
 rtl/mc_ctrl_pkg.sv | 55 +++++
 rtl/multicycle_controller_if.sv | 28 ++
 rtl/mc_condlogic.sv | 27 ++
 rtl/multicycle_controller.sv | 150 +++++++++++++++
 tb/tb_multicycle_controller.sv | 152 +++++++++++++++
 5 files changed

// File: rtl/mc_ctrl_pkg.sv
// rtl/mc_ctrl_pkg.sv - state, select and condition encodings plus condition evaluation
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB,
    S_MEMWRITE, S_EXECUTER, S_EXECUTEI, S_ALUWB, S_BRANCH
  } state_e;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00, ALU_SUB = 2'b01, ALU_AND = 2'b10, ALU_ORR = 2'b11
  } alu_ctrl_e;

  typedef enum logic [1:0] {
    RES_ALUOUT = 2'b00, RES_DATA = 2'b01, RES_ALURESULT = 2'b10
  } result_src_e;

  typedef enum logic [1:0] {
    SRCB_REG = 2'b00, SRCB_IMM = 2'b01, SRCB_FOUR = 2'b10
  } alu_src_b_e;

  typedef enum logic [3:0] {
    C_EQ, C_NE, C_CS, C_CC, C_MI, C_PL, C_VS, C_VC,
    C_HI, C_LS, C_GE, C_LT, C_GT, C_LE, C_AL, C_NV
  } cond_e;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;
  localparam logic [3:0] RD_PC  = 4'hF;

  // flags are {N,Z,C,V}; the never code evaluates false
  function automatic logic cond_eval(input logic [3:0] cond, input logic [3:0] flags);
    logic n, z, c, v;
    {n, z, c, v} = flags;
    case (cond_e'(cond))
      C_EQ:    return z;
      C_NE:    return !z;
      C_CS:    return c;
      C_CC:    return !c;
      C_MI:    return n;
      C_PL:    return !n;
      C_VS:    return v;
      C_VC:    return !v;
      C_HI:    return c && !z;
      C_LS:    return !c || z;
      C_GE:    return n == v;
      C_LT:    return n != v;
      C_GT:    return !z && (n == v);
      C_LE:    return z || (n != v);
      C_AL:    return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// rtl/multicycle_controller_if.sv - instruction/flag inputs and control outputs between datapath and controller
interface multicycle_controller_if;
  logic [19:0] Instr;
  logic [3:0]  ALUFlags;
  logic        PCWrite;
  logic        RegWrite;
  logic        MemWrite;
  logic        IRWrite;
  logic        AdrSrc;
  logic        ALUSrcA;
  logic [1:0]  ALUSrcB;
  logic [1:0]  ResultSrc;
  logic [1:0]  ImmSrc;
  logic [1:0]  RegSrc;
  logic [1:0]  ALUControl;

  modport master (
    output Instr, ALUFlags,
    input  PCWrite, RegWrite, MemWrite, IRWrite, AdrSrc, ALUSrcA,
           ALUSrcB, ResultSrc, ImmSrc, RegSrc, ALUControl
  );

  modport slave (
    input  Instr, ALUFlags,
    output PCWrite, RegWrite, MemWrite, IRWrite, AdrSrc, ALUSrcA,
           ALUSrcB, ResultSrc, ImmSrc, RegSrc, ALUControl
  );
endinterface

// File: rtl/mc_condlogic.sv
// rtl/mc_condlogic.sv - {N,Z,C,V} flags register and condition check against the stored flags
module mc_condlogic
  import mc_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] i_cond,
  input  logic [3:0] i_alu_flags,
  input  logic [1:0] i_flag_wr,
  output logic       o_cond_ex
);

  logic [3:0] r_flags;

  // i_flag_wr[1] loads N,Z; i_flag_wr[0] loads C,V
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_flags <= 4'b0000;
    end else begin
      if (i_flag_wr[1]) r_flags[3:2] <= i_alu_flags[3:2];
      if (i_flag_wr[0]) r_flags[1:0] <= i_alu_flags[1:0];
    end
  end

  assign o_cond_ex = cond_eval(i_cond, r_flags);

endmodule

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - multicycle ARM-subset control FSM and ALU decode
// MC_NOWRITE_EN: adds CMP (Funct[4:1]=1010) as a flag-only SUB.
module multicycle_controller
  import mc_ctrl_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  multicycle_controller_if.slave bus
);

  state_e      r_state;
  logic [3:0]  w_cond;
  logic [1:0]  w_op;
  logic [5:0]  w_funct;
  logic [3:0]  w_rd;
  logic        w_cond_ex;
  alu_ctrl_e   w_alu_op;
  logic        w_alu_ok;
  logic        w_alu_cv;
  logic        w_alu_nowrite;
  logic        w_pc_write, w_reg_write, w_mem_write, w_ir_write;
  logic        w_adr_src, w_alu_src_a;
  alu_src_b_e  w_alu_src_b;
  result_src_e w_result_src;
  alu_ctrl_e   w_alu_control;
  logic [1:0]  w_flag_wr;
  logic        w_unused;

  assign w_cond   = bus.Instr[19:16];
  assign w_op     = bus.Instr[15:14];
  assign w_funct  = bus.Instr[13:8];
  assign w_rd     = bus.Instr[3:0];
  assign w_unused = &{1'b0, bus.Instr[7:4]};

  mc_condlogic u_cond (
    .clk         (clk),
    .reset       (reset),
    .i_cond      (w_cond),
    .i_alu_flags (bus.ALUFlags),
    .i_flag_wr   (w_flag_wr),
    .o_cond_ex   (w_cond_ex)
  );

  // unsupported opcodes execute as ADD but never write the register file or flags
  always_comb begin
    w_alu_op      = ALU_ADD;
    w_alu_ok      = 1'b1;
    w_alu_cv      = 1'b0;
    w_alu_nowrite = 1'b0;
    case (w_funct[4:1])
      4'b0100: begin w_alu_op = ALU_ADD; w_alu_cv = 1'b1; end
      4'b0010: begin w_alu_op = ALU_SUB; w_alu_cv = 1'b1; end
      4'b0000: w_alu_op = ALU_AND;
      4'b1100: w_alu_op = ALU_ORR;
`ifdef MC_NOWRITE_EN
      4'b1010: begin w_alu_op = ALU_SUB; w_alu_cv = 1'b1; w_alu_nowrite = 1'b1; end
`endif
      default: w_alu_ok = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_FETCH;
    end else begin
      case (r_state)
        S_FETCH:  r_state <= S_DECODE;
        S_DECODE: begin
          case (w_op)
            OP_MEM:  r_state <= S_MEMADR;
            OP_DP:   r_state <= w_funct[5] ? S_EXECUTEI : S_EXECUTER;
            OP_BR:   r_state <= S_BRANCH;
            default: r_state <= S_FETCH;
          endcase
        end
        S_MEMADR:               r_state <= w_funct[0] ? S_MEMREAD : S_MEMWRITE;
        S_MEMREAD:              r_state <= S_MEMWB;
        S_EXECUTER, S_EXECUTEI: r_state <= S_ALUWB;
        default:                r_state <= S_FETCH;
      endcase
    end
  end

  always_comb begin
    w_pc_write    = 1'b0;
    w_reg_write   = 1'b0;
    w_mem_write   = 1'b0;
    w_ir_write    = 1'b0;
    w_adr_src     = 1'b0;
    w_alu_src_a   = 1'b0;
    w_alu_src_b   = SRCB_REG;
    w_result_src  = RES_ALUOUT;
    w_alu_control = ALU_ADD;
    w_flag_wr     = 2'b00;
    case (r_state)
      S_FETCH: begin
        w_ir_write   = 1'b1;
        w_pc_write   = 1'b1;
        w_alu_src_a  = 1'b1;
        w_alu_src_b  = SRCB_FOUR;
        w_result_src = RES_ALURESULT;
      end
      S_DECODE: begin
        w_alu_src_a  = 1'b1;
        w_alu_src_b  = SRCB_FOUR;
        w_result_src = RES_ALURESULT;
      end
      S_MEMADR:  w_alu_src_b = SRCB_IMM;
      S_MEMREAD: w_adr_src   = 1'b1;
      S_MEMWB: begin
        w_result_src = RES_DATA;
        w_reg_write  = w_cond_ex;
      end
      S_MEMWRITE: begin
        w_adr_src   = 1'b1;
        w_mem_write = w_cond_ex;
      end
      S_EXECUTER, S_EXECUTEI: begin
        if (r_state == S_EXECUTEI) w_alu_src_b = SRCB_IMM;
        w_alu_control = w_alu_op;
        w_flag_wr[1]  = w_funct[0] && w_cond_ex && w_alu_ok;
        w_flag_wr[0]  = w_funct[0] && w_cond_ex && w_alu_ok && w_alu_cv;
      end
      S_ALUWB: begin
        if (w_rd == RD_PC) w_pc_write  = w_cond_ex && w_alu_ok && !w_alu_nowrite;
        else               w_reg_write = w_cond_ex && w_alu_ok && !w_alu_nowrite;
      end
      S_BRANCH: begin
        w_alu_src_b  = SRCB_IMM;
        w_result_src = RES_ALURESULT;
        w_pc_write   = w_cond_ex;
      end
      default: ;
    endcase
  end

  // reset holds the FSM in FETCH, so its unconditional writes must be masked here
  assign bus.PCWrite    = w_pc_write  && !reset;
  assign bus.RegWrite   = w_reg_write && !reset;
  assign bus.MemWrite   = w_mem_write && !reset;
  assign bus.IRWrite    = w_ir_write  && !reset;
  assign bus.AdrSrc     = w_adr_src;
  assign bus.ALUSrcA    = w_alu_src_a;
  assign bus.ALUSrcB    = w_alu_src_b;
  assign bus.ResultSrc  = w_result_src;
  assign bus.ALUControl = w_alu_control;
  assign bus.ImmSrc     = w_op;
  assign bus.RegSrc     = {w_op == OP_MEM, w_op == OP_BR};

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - directed vector bench for multicycle_controller
module tb_multicycle_controller;
  import mc_ctrl_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;

  multicycle_controller_if bus ();

  multicycle_controller dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [19:0] instr;
    logic [3:0]  alu_flags;
    int          cycles;
    int          rw;
    int          mw;
    int          pcw;
    logic [1:0]  alu;
    logic [3:0]  flags;
  } vec_t;

  localparam int NV = 20;
  vec_t vecs [NV];

  function automatic logic [19:0] mk(input logic [3:0] c, input logic [1:0] op,
                                     input logic [5:0] f, input logic [3:0] rd);
    return {c, op, f, 4'h0, rd};
  endfunction

  task automatic check(input int idx, input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL v%0d %s: got %0h expected %0h", idx, name, act, exp);
    end
  endtask

  // entered in the FETCH cycle, returns in the next instruction's FETCH cycle
  task automatic run_instr(input int idx);
    int n, rw, mw, pcw;
    logic [1:0] alu;
    logic [1:0] op;
    n = 99; rw = 0; mw = 0; pcw = 0; alu = 2'b00;
    bus.Instr    = vecs[idx].instr;
    bus.ALUFlags = vecs[idx].alu_flags;
    op = vecs[idx].instr[15:14];
    #1;
    check(idx, "fetch_irwrite", bus.IRWrite, 1);
    check(idx, "fetch_pcwrite", bus.PCWrite, 1);
    check(idx, "immsrc", bus.ImmSrc, op);
    check(idx, "regsrc", bus.RegSrc, {op == 2'b01, op == 2'b10});
    for (int c = 2; c <= 9; c++) begin
      @(posedge clk); #1;
      if (bus.IRWrite) begin
        n = c - 1;
        break;
      end
      if (bus.RegWrite) rw = c;
      if (bus.MemWrite) mw = c;
      if (bus.PCWrite)  pcw = c;
      if (c == 3) alu = bus.ALUControl;
    end
    check(idx, "cycles", n, vecs[idx].cycles);
    check(idx, "regwrite_cycle", rw, vecs[idx].rw);
    check(idx, "memwrite_cycle", mw, vecs[idx].mw);
    check(idx, "pcwrite_cycle", pcw, vecs[idx].pcw);
    check(idx, "alucontrol", alu, vecs[idx].alu);
    check(idx, "flags", dut.u_cond.r_flags, vecs[idx].flags);
  endtask

  initial begin
`ifdef MC_NOWRITE_EN
    logic [3:0] fl_cmp = 4'b0110;
    logic [1:0] alu_cmp = 2'b01;
`else
    logic [3:0] fl_cmp = 4'b0100;
    logic [1:0] alu_cmp = 2'b00;
`endif
    vecs[0]  = '{mk(4'hE, 2'b01, 6'b011001, 4'h1), 4'h0, 5, 5, 0, 0, 2'b00, 4'b0000};
    vecs[1]  = '{mk(4'hE, 2'b01, 6'b011000, 4'h2), 4'h0, 4, 0, 4, 0, 2'b00, 4'b0000};
    vecs[2]  = '{mk(4'hE, 2'b00, 6'b001000, 4'h3), 4'hF, 4, 4, 0, 0, 2'b00, 4'b0000};
    vecs[3]  = '{mk(4'hE, 2'b00, 6'b001001, 4'h1), 4'h4, 4, 4, 0, 0, 2'b00, 4'b0100};
    vecs[4]  = '{mk(4'h0, 2'b10, 6'b100000, 4'h0), 4'h0, 3, 0, 0, 3, 2'b00, 4'b0100};
    vecs[5]  = '{mk(4'h1, 2'b10, 6'b100000, 4'h0), 4'h0, 3, 0, 0, 0, 2'b00, 4'b0100};
    vecs[6]  = '{mk(4'hE, 2'b00, 6'b000100, 4'h4), 4'h0, 4, 4, 0, 0, 2'b01, 4'b0100};
    vecs[7]  = '{mk(4'hE, 2'b00, 6'b011000, 4'h5), 4'h0, 4, 4, 0, 0, 2'b11, 4'b0100};
    vecs[8]  = '{mk(4'hE, 2'b00, 6'b100000, 4'h6), 4'h0, 4, 4, 0, 0, 2'b10, 4'b0100};
    vecs[9]  = '{mk(4'hE, 2'b00, 6'b001000, 4'hF), 4'h0, 4, 0, 0, 4, 2'b00, 4'b0100};
    vecs[10] = '{mk(4'hE, 2'b11, 6'b000000, 4'h0), 4'h0, 2, 0, 0, 0, 2'b00, 4'b0100};
    vecs[11] = '{mk(4'hE, 2'b00, 6'b000011, 4'h7), 4'hF, 4, 0, 0, 0, 2'b00, 4'b0100};
    vecs[12] = '{mk(4'hE, 2'b00, 6'b010101, 4'h0), 4'h6, 4, 0, 0, 0, alu_cmp, fl_cmp};
    vecs[13] = '{mk(4'h1, 2'b01, 6'b011001, 4'h1), 4'h0, 5, 0, 0, 0, 2'b00, fl_cmp};
    vecs[14] = '{mk(4'hF, 2'b01, 6'b011000, 4'h2), 4'h0, 4, 0, 0, 0, 2'b00, fl_cmp};
    vecs[15] = '{mk(4'h1, 2'b00, 6'b001001, 4'h1), 4'h8, 4, 0, 0, 0, 2'b00, fl_cmp};
    vecs[16] = '{mk(4'hE, 2'b00, 6'b101001, 4'h1), 4'h3, 4, 4, 0, 0, 2'b00, 4'b0011};
    vecs[17] = '{mk(4'hE, 2'b00, 6'b011001, 4'h1), 4'hC, 4, 4, 0, 0, 2'b11, 4'b1111};
    vecs[18] = '{mk(4'h8, 2'b10, 6'b100000, 4'h0), 4'h0, 3, 0, 0, 0, 2'b00, 4'b1111};
    vecs[19] = '{mk(4'hA, 2'b10, 6'b100000, 4'h0), 4'h0, 3, 0, 0, 3, 2'b00, 4'b1111};

    reset = 1'b1;
    bus.Instr = '0;
    bus.ALUFlags = '0;
    repeat (2) @(posedge clk);
    #1;
    check(-1, "rst_pcwrite", bus.PCWrite, 0);
    check(-1, "rst_irwrite", bus.IRWrite, 0);
    check(-1, "rst_regwrite", bus.RegWrite, 0);
    check(-1, "rst_memwrite", bus.MemWrite, 0);
    check(-1, "rst_flags", dut.u_cond.r_flags, 4'b0000);
    check(-1, "rst_state", dut.r_state, S_FETCH);
    reset = 1'b0;

    for (int i = 0; i < NV; i++) run_instr(i);

    // abort an LDR in MEMREAD with an asynchronous reset
    bus.Instr = mk(4'hE, 2'b01, 6'b011001, 4'h1);
    repeat (3) begin @(posedge clk); #1; end
    check(-2, "memread_adrsrc", bus.AdrSrc, 1);
    #2 reset = 1'b1;
    #1;
    check(-2, "abort_state", dut.r_state, S_FETCH);
    check(-2, "abort_flags", dut.u_cond.r_flags, 4'b0000);
    check(-2, "abort_regwrite", bus.RegWrite, 0);
    check(-2, "abort_pcwrite", bus.PCWrite, 0);
    @(posedge clk); #1;
    check(-2, "held_irwrite", bus.IRWrite, 0);
    check(-2, "held_regwrite", bus.RegWrite, 0);
    reset = 1'b0;
    #1;
    check(-2, "rel_irwrite", bus.IRWrite, 1);
    check(-2, "rel_pcwrite", bus.PCWrite, 1);
    check(-2, "rel_alusrcb", bus.ALUSrcB, 2'b10);
    check(-2, "rel_resultsrc", bus.ResultSrc, 2'b10);
    @(posedge clk); #1;
    check(-2, "decode_irwrite", bus.IRWrite, 0);
    check(-2, "decode_pcwrite", bus.PCWrite, 0);
    check(-2, "decode_regwrite", bus.RegWrite, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
